seq_mac_unit: RTL and testbench
===============================

Name: seq_mac_unit

Overview:
Parametrised sequential shift-add multiply / multiply-accumulate unit for the datapath. Supports unsigned and signed multiply, with optional accumulate into an internal 2*WIDTH accumulator. Uses a start/busy/done handshake and a registered read-out op. It is the next generation of the fixed 32-bit unsigned multiplier. The ALU control issues 6-bit Signal op codes to it.

Parameters:
WIDTH, 32, operand width in bits (>=4, even); product/accumulator width is 2*WIDTH

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
Signal  input  6  op code, sampled only when start=1
start  input  1  op request, one-cycle qualifier for Signal/dataA/dataB
dataA  input  WIDTH  multiplicand
dataB  input  WIDTH  multiplier
busy  output  1  registered; high while an arithmetic op is in progress
done  output  1  registered; one-cycle pulse when acc has been updated
dataOut  output  2*WIDTH  registered accumulator snapshot

Behaviour:
- Op codes (localparams):
  - MULT 011000: signed, acc = A*B
  - MULTU 011001: unsigned, acc = A*B
  - MADD 000000: signed, acc += A*B
  - MADDU 000001: unsigned, acc += A*B
  - OUT 111111: dataOut <= acc
- Reset (reset=1 at a rising edge): state=IDLE, acc=0, dataOut=0, busy=0, done=0, internal regs=0. Reset mid-operation aborts the op; no partial result is written.
- Accept rule: an op is accepted at edge k only if start=1 and state=IDLE.
  - start while busy is ignored. It is not queued.
  - start with an unrecognised code is ignored; no state change.
- OUT accepted at edge k: dataOut <= acc at edge k; no busy; done is not asserted.
- FSM states: IDLE, RUN, FIX. busy = (state != IDLE).
- IDLE -> RUN (arithmetic op accepted at edge k):
  - Latch op.
  - For signed ops, latch neg = sign(A) XOR sign(B).
  - Load mcand = |A| zero-extended to 2*WIDTH, mplier = |B|, prod = 0, cnt = 0.
  - Unsigned ops take A and B as-is, with neg = 0.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1), which fits WIDTH bits unsigned.
- RUN, one step per cycle:
  - if mplier[0]: prod += mcand
  - mplier >>= 1; mcand <<= 1; cnt++
  - After WIDTH steps (edge k+WIDTH), go to FIX.
- FIX (edge k+WIDTH+1):
  - res = neg ? -prod : prod.
  - acc <= res (MULT/MULTU) or acc + res (MADD/MADDU), modulo 2^(2*WIDTH), no saturation, no overflow flag.
  - done <= 1, state <= IDLE.
- Latency: busy high for exactly WIDTH+1 cycles after the accept edge. done is high in the cycle after edge k+WIDTH+1. A new start is accepted in that same cycle (back-to-back issue).
- OUT issued in the done cycle sees the updated acc.
- done is 0 in all other cycles. dataOut changes only on OUT or reset.
- Inputs dataA/dataB are don't-care except at the accept edge.

Optional Feature:
MSUB_EN
- Defined:
  - Adds MSUB 000100 (signed, acc -= A*B) and MSUBU 000101 (unsigned, acc -= A*B).
  - Same FSM and latency; FIX computes acc - res modulo 2^(2*WIDTH).
- Undefined: 000100/000101 are unrecognised codes and ignored like any other.

Test Plan:
- WIDTH=32. Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF, then OUT. Required: done exactly 33 cycles after the accept edge, busy high for 33 cycles, dataOut=0xFFFFFFFE00000001.
- MULT A=-3 (0xFFFFFFFD) B=5, then OUT -> dataOut=0xFFFFFFFFFFFFFFF1. MULT A=0x80000000 B=0x80000000, then OUT -> 0x4000000000000000.
- MULTU 7*6, MADDU 10*10, MADD -2*50, then OUT -> dataOut=0x000000000000002A (42+100-100). Each op is issued in the previous op's done cycle; no gaps, all accepted.
- start=1 MULTU 2*2 while busy, mid-op of 3*3 -> ignored. OUT after done gives 9. Unrecognised code 0x2A with start -> no busy, no done, acc unchanged.
- reset asserted 10 cycles into MADDU after acc was loaded with 0x55 -> the cycle after that reset edge: busy=0, done=0. Subsequent OUT gives dataOut=0. No done pulse from the aborted op.
- With MSUB_EN, WIDTH=8: MULTU 0x10*0x10, MSUB 0x03*0xFE, OUT -> dataOut=0x0106 (256 - (-6)). Latency 9 cycles. Without MSUB_EN, code 000100 is ignored.

Source files
------------

// File: rtl/seq_mac_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mac_unit
// Purpose  : Sequential shift-add multiply / multiply-accumulate unit with a
//            start/busy/done handshake and a registered accumulator read-out.
//            Optional macro MSUB_EN adds the MSUB/MSUBU (acc -= A*B) op codes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mac_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Signal,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] c_OP_MULT  = 6'b011000;
    localparam logic [5:0] c_OP_MULTU = 6'b011001;
    localparam logic [5:0] c_OP_MADD  = 6'b000000;
    localparam logic [5:0] c_OP_MADDU = 6'b000001;
    localparam logic [5:0] c_OP_OUT   = 6'b111111;
`ifdef MSUB_EN
    localparam logic [5:0] c_OP_MSUB  = 6'b000100;
    localparam logic [5:0] c_OP_MSUBU = 6'b000101;
`endif

    // How the finished product is folded into the accumulator
    localparam logic [1:0] c_MODE_LOAD = 2'd0;
    localparam logic [1:0] c_MODE_ADD  = 2'd1;
    localparam logic [1:0] c_MODE_SUB  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_mode;
    logic                r_neg;
    logic [c_PW-1:0]     r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [c_PW-1:0]     r_prod;
    logic [c_CW-1:0]     r_cnt;
    logic [c_PW-1:0]     r_acc;
    logic [c_PW-1:0]     r_dout;
    logic                r_busy;
    logic                r_done;

    logic                w_arith;
    logic                w_signed;
    logic                w_out;
    logic [1:0]          w_mode;
    logic                w_idle;
    logic                w_accept;
    logic                w_out_acc;
    logic                w_last;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [c_PW-1:0]     w_step_prod;
    logic [c_PW-1:0]     w_res;
    logic [c_PW-1:0]     w_acc_nxt;

    // Op-code decode; anything not listed is silently ignored
    always_comb begin
        w_arith  = 1'b0;
        w_signed = 1'b0;
        w_out    = 1'b0;
        w_mode   = c_MODE_LOAD;
        case (Signal)
            c_OP_MULT: begin
                w_arith  = 1'b1;
                w_signed = 1'b1;
            end
            c_OP_MULTU: begin
                w_arith  = 1'b1;
            end
            c_OP_MADD: begin
                w_arith  = 1'b1;
                w_signed = 1'b1;
                w_mode   = c_MODE_ADD;
            end
            c_OP_MADDU: begin
                w_arith  = 1'b1;
                w_mode   = c_MODE_ADD;
            end
`ifdef MSUB_EN
            c_OP_MSUB: begin
                w_arith  = 1'b1;
                w_signed = 1'b1;
                w_mode   = c_MODE_SUB;
            end
            c_OP_MSUBU: begin
                w_arith  = 1'b1;
                w_mode   = c_MODE_SUB;
            end
`endif
            c_OP_OUT: begin
                w_out    = 1'b1;
            end
            default: begin
                w_arith  = 1'b0;
            end
        endcase
    end

    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = start & w_idle & w_arith;
    assign w_out_acc = start & w_idle & w_out;
    assign w_last    = (r_cnt == c_CW'(WIDTH - 1));

    // Magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned
    assign w_neg_a = w_signed & dataA[WIDTH-1];
    assign w_neg_b = w_signed & dataB[WIDTH-1];
    assign w_abs_a = w_neg_a ? (~dataA + 1'b1) : dataA;
    assign w_abs_b = w_neg_b ? (~dataB + 1'b1) : dataB;

    assign w_step_prod = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_res       = r_neg ? (~r_prod + 1'b1) : r_prod;

    always_comb begin
        w_acc_nxt = w_res;
        case (r_mode)
            c_MODE_ADD:  w_acc_nxt = r_acc + w_res;
            c_MODE_SUB:  w_acc_nxt = r_acc - w_res;
            default:     w_acc_nxt = w_res;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode   <= c_MODE_LOAD;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_dout   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_acc) begin
                r_dout <= r_acc;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode   <= w_mode;
                        r_neg    <= w_neg_a ^ w_neg_b;
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_prod   <= w_step_prod;
                    r_mplier <= r_mplier >> 1;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_acc  <= w_acc_nxt;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_seq_mac_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_mac_unit
// Purpose  : Directed self-checking bench for seq_mac_unit (WIDTH=32) with a
//            transaction-level accumulator model; honours MSUB_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mac_unit;

    localparam int W  = 32;
    localparam int PW = 2 * W;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MADD  = 6'b000000;
    localparam logic [5:0] OP_MADDU = 6'b000001;
    localparam logic [5:0] OP_MSUB  = 6'b000100;
    localparam logic [5:0] OP_MSUBU = 6'b000101;
    localparam logic [5:0] OP_OUT   = 6'b111111;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    Signal;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic          busy;
    logic          done;
    logic [PW-1:0] dataOut;

    always #5 clk = ~clk;

    seq_mac_unit #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .Signal  (Signal),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Exact product modulo 2^PW: sign/zero extend then multiply
    function automatic logic [PW-1:0] mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Transaction-level model: an accepted op occupies W+1 cycles, then commits
    logic [PW-1:0] m_acc  = '0;
    logic [PW-1:0] m_dout = '0;
    logic [PW-1:0] m_pend = '0;
    int            m_left = 0;
    logic          m_done = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_acc  = '0;
            m_dout = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_acc  = m_pend;
                m_done = 1'b1;
            end
        end else if (start) begin
            case (Signal)
                OP_MULT:  begin m_pend = mul(1'b1, dataA, dataB);         m_left = W + 1; end
                OP_MULTU: begin m_pend = mul(1'b0, dataA, dataB);         m_left = W + 1; end
                OP_MADD:  begin m_pend = m_acc + mul(1'b1, dataA, dataB); m_left = W + 1; end
                OP_MADDU: begin m_pend = m_acc + mul(1'b0, dataA, dataB); m_left = W + 1; end
`ifdef MSUB_EN
                OP_MSUB:  begin m_pend = m_acc - mul(1'b1, dataA, dataB); m_left = W + 1; end
                OP_MSUBU: begin m_pend = m_acc - mul(1'b0, dataA, dataB); m_left = W + 1; end
`endif
                OP_OUT:   m_dout = m_acc;
                default:  ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(busy), 64'(m_left > 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_dataOut", dataOut, m_dout);
        end
    end

    // Caller sits at a negedge; start is held across exactly one rising edge
    task automatic go(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Signal = op;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        Signal = 6'($urandom);
        dataA  = $urandom;
        dataB  = $urandom;
    endtask

    task automatic wait_done(output int c, output int nb);
        c  = 0;
        nb = 0;
        while (done !== 1'b1 && c < 200) begin
            nb += int'(busy === 1'b1);
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: timeout after %0d cycles, done never rose", c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nb;
        int nd;
        reset  = 1'b1;
        start  = 1'b0;
        Signal = '0;
        dataA  = '0;
        dataB  = '0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dataOut", dataOut, 64'd0);

        go(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(c, nb);
        check("multu_latency", 64'(c), 64'd33);
        check("multu_busy_len", 64'(nb), 64'd33);
        go(OP_OUT, '0, '0);
        check("multu_ff", dataOut, 64'hFFFFFFFE00000001);

        go(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(c, nb);
        go(OP_OUT, '0, '0);
        check("mult_m3x5", dataOut, 64'hFFFFFFFFFFFFFFF1);

        go(OP_MULT, 32'h80000000, 32'h80000000);
        wait_done(c, nb);
        go(OP_OUT, '0, '0);
        check("mult_minxmin", dataOut, 64'h4000000000000000);

        // Back-to-back chain, each op issued in the previous done cycle
        go(OP_MULTU, 32'd7, 32'd6);
        wait_done(c, nb);
        check("chain1_latency", 64'(c), 64'd33);
        go(OP_MADDU, 32'd10, 32'd10);
        wait_done(c, nb);
        check("chain2_latency", 64'(c), 64'd33);
        go(OP_MADD, 32'hFFFFFFFE, 32'd50);
        wait_done(c, nb);
        check("chain3_latency", 64'(c), 64'd33);
        go(OP_OUT, '0, '0);
        check("chain_result", dataOut, 64'h000000000000002A);

        // Start while busy must be dropped, not restart the op
        go(OP_MULTU, 32'd3, 32'd3);
        repeat (5) @(negedge clk);
        go(OP_MULTU, 32'd2, 32'd2);
        wait_done(c, nb);
        check("ignored_latency", 64'(c), 64'd27);
        go(OP_OUT, '0, '0);
        check("ignored_result", dataOut, 64'd9);

        go(6'h2A, 32'd1, 32'd1);
        check("badop_busy", 64'(busy), 64'd0);
        check("badop_done", 64'(done), 64'd0);
        go(OP_OUT, '0, '0);
        check("badop_acc", dataOut, 64'd9);

`ifdef MSUB_EN
        go(OP_MULTU, 32'h10, 32'h10);
        wait_done(c, nb);
        go(OP_MSUB, 32'd3, 32'hFFFFFFFE);
        wait_done(c, nb);
        check("msub_latency", 64'(c), 64'd33);
        go(OP_OUT, '0, '0);
        check("msub_result", dataOut, 64'h0000000000000106);
        go(OP_MSUBU, 32'd6, 32'd1);
        wait_done(c, nb);
        go(OP_OUT, '0, '0);
        check("msubu_result", dataOut, 64'h0000000000000100);
`else
        go(OP_MSUB, 32'd3, 32'd3);
        check("msub_off_busy", 64'(busy), 64'd0);
        go(OP_OUT, '0, '0);
        check("msub_off_acc", dataOut, 64'd9);
`endif

        // Reset mid-op aborts without a done pulse or partial result
        go(OP_MULTU, 32'h55, 32'd1);
        wait_done(c, nb);
        go(OP_OUT, '0, '0);
        check("preload_55", dataOut, 64'h55);
        go(OP_MADDU, 32'd1, 32'd1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        nd = 0;
        repeat (45) begin
            @(negedge clk);
            nd += int'(done === 1'b1);
        end
        check("abort_no_done", 64'(nd), 64'd0);
        go(OP_OUT, '0, '0);
        check("abort_acc", dataOut, 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
